// File: rtl/regdump_sequencer.sv
// Run-then-dump controller: resets the core, lets it run a fixed number of
// clocks, then freezes it and streams every register out over valid/ready.
module regdump_sequencer #(
    parameter int RUN_CYCLES = 2000,
    parameter int NUM_REGS   = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             cpu_reset,
    output logic             cpu_run,
    output logic             test_mode,
    output logic [4:0]       dump_addr,
    input  logic [31:0]      reg_data,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [4:0]       dump_index,
    output logic [31:0]      dump_data,
    output logic [CNT_W-1:0] cycle_count,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_DUMP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam bit HAS_RUN = (RUN_CYCLES > 0);
    localparam logic [CNT_W-1:0] RUN_LAST =
        HAS_RUN ? CNT_W'(RUN_CYCLES - 1) : '0;
    localparam logic [4:0] REG_LAST = 5'(NUM_REGS - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       addr_q, addr_d;
    logic [4:0]       index_q, index_d;
    logic [31:0]      data_q, data_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        index_d = index_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLR;
            end
            S_CLR: begin
                count_d = '0;
                addr_d  = '0;
                state_d = HAS_RUN ? S_RUN : S_SETTLE;
            end
            S_RUN: begin
                count_d = count_q + 1'b1;
                if (count_q == RUN_LAST) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // regfile read is combinational, so the value is valid here
                data_d  = reg_data;
                index_d = addr_q;
                state_d = S_DUMP;
            end
            S_DUMP: begin
                if (dump_ready) begin
                    if (index_q == REG_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                if (start) state_d = S_CLR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            index_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            index_q <= index_d;
            data_q  <= data_d;
        end
    end

    // test_mode covers SETTLE..DONE so the core never drives rs1 while frozen
    assign cpu_reset   = (state_q == S_CLR);
    assign cpu_run     = (state_q == S_RUN);
    assign test_mode   = (state_q == S_SETTLE) || (state_q == S_DUMP) ||
                         (state_q == S_DONE);
    assign dump_valid  = (state_q == S_DUMP);
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = (state_q == S_DONE);
    assign dump_addr   = addr_q;
    assign dump_index  = index_q;
    assign dump_data   = data_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_regdump_sequencer.sv
// Self-checking bench for regdump_sequencer: a beat/cycle model checked every
// cycle plus directed scenarios (RUN_CYCLES=5 and RUN_CYCLES=0 instances).
module tb_regdump_sequencer;

    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] regs [32];

    logic          start = 1'b0, ready = 1'b1;
    logic          cpu_reset, cpu_run, test_mode, dump_valid, busy, done;
    logic [4:0]    dump_addr, dump_index;
    logic [31:0]   dump_data, reg_data;
    logic [CW-1:0] cycle_count;

    logic          start0 = 1'b0, ready0 = 1'b1;
    logic          cpu_reset0, cpu_run0, test_mode0, dump_valid0, busy0, done0;
    logic [4:0]    dump_addr0, dump_index0;
    logic [31:0]   dump_data0, reg_data0;
    logic [CW-1:0] cycle_count0;

    assign reg_data  = regs[dump_addr];
    assign reg_data0 = regs[dump_addr0];

    regdump_sequencer #(.RUN_CYCLES(5), .NUM_REGS(32), .CNT_W(CW)) u_dut (
        .clock(clk), .reset(rst_n), .start(start),
        .cpu_reset(cpu_reset), .cpu_run(cpu_run), .test_mode(test_mode),
        .dump_addr(dump_addr), .reg_data(reg_data),
        .dump_valid(dump_valid), .dump_ready(ready),
        .dump_index(dump_index), .dump_data(dump_data),
        .cycle_count(cycle_count), .busy(busy), .done(done)
    );

    regdump_sequencer #(.RUN_CYCLES(0), .NUM_REGS(32), .CNT_W(CW)) u_dut0 (
        .clock(clk), .reset(rst_n), .start(start0),
        .cpu_reset(cpu_reset0), .cpu_run(cpu_run0), .test_mode(test_mode0),
        .dump_addr(dump_addr0), .reg_data(reg_data0),
        .dump_valid(dump_valid0), .dump_ready(ready0),
        .dump_index(dump_index0), .dump_data(dump_data0),
        .cycle_count(cycle_count0), .busy(busy0), .done(done0)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Model for the RUN_CYCLES=5 instance
    int run_cnt = 0, exp_idx = 0, beats = 0, clr_len = 0, clr_pulses = 0;
    logic prev_cr = 1'b0;
    logic [31:0] got_data [32];

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_outputs", {cpu_reset, cpu_run, test_mode, dump_valid,
                  busy, done, dump_addr, dump_index, cycle_count}, 0);
            check("rst_data", dump_data, 0);
            run_cnt = 0; exp_idx = 0; beats = 0;
            prev_cr = 1'b0;
        end else begin
            if (cpu_reset) begin
                clr_len = prev_cr ? clr_len + 1 : 1;
                if (!prev_cr) clr_pulses++;
                run_cnt = 0; exp_idx = 0; beats = 0;
            end else begin
                check("cycle_count", cycle_count, run_cnt);
            end
            prev_cr = cpu_reset;
            if (cpu_run) begin
                check("run_not_test", test_mode, 0);
                run_cnt++;
            end
            check("busy_done_excl", busy & done, 0);
            if (dump_valid) begin
                check("valid_test_mode", test_mode, 1);
                if (exp_idx < 32) begin
                    check("beat_index", dump_index, exp_idx);
                    check("beat_data", dump_data, regs[exp_idx]);
                    if (ready) begin
                        got_data[exp_idx] = dump_data;
                        exp_idx++;
                        beats++;
                    end
                end else begin
                    check("extra_beat", dump_valid, 0);
                end
            end
        end
    end

    // Model for the RUN_CYCLES=0 instance
    int run0 = 0, exp0 = 0, beats0 = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp0 = 0; beats0 = 0;
        end else begin
            check("cc0_zero", cycle_count0, 0);
            if (cpu_run0) run0++;
            if (cpu_reset0) begin
                exp0 = 0; beats0 = 0;
            end
            if (dump_valid0 && exp0 < 32) begin
                check("beat0_index", dump_index0, exp0);
                check("beat0_data", dump_data0, regs[exp0]);
                if (ready0) begin
                    exp0++;
                    beats0++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick(); start = 1'b1;
        tick(); start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        check("done_timeout", done, 1);
    endtask

    task automatic wait_beat(input int idx);
        int n = 0;
        while (!(dump_valid && dump_index == 5'(idx)) && n < 400) begin
            tick();
            n++;
        end
        check("beat_wait", dump_valid, 1);
    endtask

    initial begin
        int n, pulses;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
        regs[0] = 32'h0;
        regs[7] = 32'hDEAD_BEEF;
        repeat (2) tick();
        check("reset_idle", {busy, done, cpu_reset}, 0);
        tick(); rst_n = 1'b1;
        tick();

        // 1+2: basic run with preloaded registers
        ready = 1'b1;
        pulse_start();
        check("clr_cpu_reset", cpu_reset, 1);
        check("clr_busy", busy, 1);
        wait_done(n);
        check("t1_latency", n, 70);
        check("t1_clr_len", clr_len, 1);
        check("t1_run_cycles", run_cnt, 5);
        check("t1_cycle_count", cycle_count, 5);
        check("t1_beats", beats, 32);
        check("t1_r0", got_data[0], 32'h0);
        check("t1_r7", got_data[7], 32'hDEAD_BEEF);
        check("t1_r31", got_data[31], 32'hA5A5_0000 ^ (31 * 32'h0101_0101));
        check("t1_done_state", {done, busy, dump_valid, test_mode}, 4'b1001);

        // 3: backpressure on beat 3
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        pulse_start();
        wait_beat(3);
        ready = 1'b0;
        repeat (2) begin
            tick();
            check("t3_hold_valid", dump_valid, 1);
            check("t3_hold_index", dump_index, 3);
            check("t3_hold_data", dump_data, regs[3]);
        end
        ready = 1'b1;
        tick();
        check("t3_settle", dump_valid, 0);
        tick();
        check("t3_next_index", dump_index, 4);
        wait_done(n);
        check("t3_beats", beats, 32);
        check("t3_latency_total", n > 0, 1);

        // 4: RUN_CYCLES=0 instance
        tick(); start0 = 1'b1;
        tick(); start0 = 1'b0;
        check("t4_clr", cpu_reset0, 1);
        n = 0;
        while (!done0 && n < 400) begin
            tick();
            n++;
        end
        check("t4_done", done0, 1);
        check("t4_latency", n, 65);
        check("t4_no_run", run0, 0);
        check("t4_beats", beats0, 32);

        // 5: async reset during RUN
        pulse_start();
        n = 0;
        while (cycle_count != 3 && n < 50) begin
            tick();
            n++;
        end
        check("t5_run3", {cpu_run, cycle_count}, {1'b1, 16'd3});
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_zero", {cpu_run, busy, test_mode, cycle_count}, 0);
        tick(); tick();
        rst_n = 1'b1;
        check("t5_done0_cleared", done0, 0);
        tick();
        pulse_start();
        wait_done(n);
        check("t5_latency", n, 70);
        check("t5_cycle_count", cycle_count, 5);
        check("t5_beats", beats, 32);

        // 6: start during DUMP ignored, start in DONE restarts
        pulse_start();
        wait_beat(10);
        pulses = clr_pulses;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        check("t6_ignored", clr_pulses, pulses);
        check("t6_beats1", beats, 32);
        pulse_start();
        check("t6_done_clr", {done, cpu_reset}, 2'b01);
        tick();
        check("t6_run", {cpu_reset, cpu_run, cycle_count}, {2'b01, 16'd0});
        wait_done(n);
        check("t6_latency", n, 69);
        check("t6_cycle_count", cycle_count, 5);
        check("t6_beats2", beats, 32);
        check("t6_pulses", clr_pulses, pulses + 1);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
